txrx_seq: RTL

- Parametrised successor to the single-shot TX/RX register block.
- Adds a TX byte FIFO and an RX byte FIFO, a mode-driven sequencer (TX only, RX only, or TX then RX turnaround), an RX access-address search timeout, and a maskable sticky interrupt.
- Sits between the CPU bus and the tx / rx / fsk_demod cores and drives their start, enable and config inputs.

---
 rtl/txrx_seq.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/txrx_seq.sv
// txrx_seq: CPU register block with TX/RX byte FIFOs,
// mode sequencer, AA-search timeout and sticky IRQ.
module txrx_seq #(
  parameter int          ADDR_W   = 4,
  parameter int          TXF_LOG2 = 5,
  parameter int          RXF_LOG2 = 6,
  parameter int          CH_IDX_W = 6,
  parameter int          TMO_W    = 16,
  parameter logic [31:0] AA_RST   = 32'h8E89BED6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   address,
  input  logic [31:0]         wdata,
  input  logic                wstrb,
  output logic [31:0]         rdata,
  output logic                ready,
  output logic [7:0]          txd_data,
  output logic                txd_valid,
  input  logic                txd_ready,
  output logic                txd_start,
  input  logic                txd_busy,
  input  logic [7:0]          rxd_data,
  input  logic                rxd_valid,
  input  logic                rxd_aa_found,
  input  logic                rxd_done,
  input  logic                rxd_crc_ok,
  output logic                rxd_start,
  output logic                tx_en,
  output logic                rx_en,
  output logic [31:0]         aa,
  output logic [CH_IDX_W-1:0] ch_idx,
  output logic                irq
);

  typedef enum logic [2:0] {
    IDLE, TX_GO, TX_RUN, RX_GO, RX_SEARCH, RX_RUN
  } state_t;

  localparam int TXD = 1 << TXF_LOG2;
  localparam int RXD = 1 << RXF_LOG2;

  state_t             state, state_d;
  logic [1:0]         mode;
  logic [TMO_W-1:0]   tmo, tmo_cnt;
  logic [4:0]         irq_en, irq_stat, irq_set, irq_clr;
  logic               crc_q, aa_hit, seen_busy;

  logic [7:0]          txm [TXD];
  logic [TXF_LOG2-1:0] tx_wp, tx_rp;
  logic [TXF_LOG2:0]   tx_lvl;
  logic [7:0]          rxm [RXD];
  logic [RXF_LOG2-1:0] rx_wp, rx_rp;
  logic [RXF_LOG2:0]   rx_lvl;

  logic [11:0] sel;
  logic        acc, we, re, busy;
  logic        start, abort;
  logic        tx_empty, tx_full, rx_empty, rx_full;
  logic        tx_push, tx_pop, rx_push, rx_pop;
  logic        tx_done_ev, tmo_ev, rx_done_ev;
  logic [31:0] rd_d;

  // one-hot register select
  always_comb begin
    sel = '0;
    for (int i = 0; i < 12; i++)
      sel[i] = (32'(address) == 32'(i));
  end

  assign acc   = valid & ~ready;
  assign we    = acc & wstrb;
  assign re    = acc & ~wstrb;
  assign busy  = (state != IDLE);
  assign abort = we & sel[0] & wdata[1];
  assign start = we & sel[0] & wdata[0] & ~wdata[1]
               & ~busy & (mode != 2'd3);

  assign tx_empty = (tx_lvl == '0);
  assign tx_full  = tx_lvl[TXF_LOG2];
  assign rx_empty = (rx_lvl == '0);
  assign rx_full  = rx_lvl[RXF_LOG2];

  assign txd_valid = (state == TX_RUN) & ~tx_empty;
  assign txd_data  = txd_valid ? txm[tx_rp] : 8'h0;
  assign txd_start = (state == TX_GO);
  assign rxd_start = (state == RX_GO);

  assign tx_push = we & sel[5] & ~tx_full;
  assign tx_pop  = txd_valid & txd_ready;
  assign rx_push = (state == RX_RUN) & rxd_valid & ~rx_full;
  assign rx_pop  = re & sel[6] & ~rx_empty;

  assign rx_done_ev = (state == RX_RUN) & rxd_done & ~abort;
  assign irq_set = {we & sel[5] & tx_full,
                    (state == RX_RUN) & rxd_valid & rx_full,
                    tmo_ev, rx_done_ev, tx_done_ev};
  assign irq_clr = (we & sel[11]) ? wdata[4:0] : 5'h0;
  assign irq     = |(irq_stat & irq_en);

  // sequencer next state; abort overrides everything
  always_comb begin
    state_d    = state;
    tx_done_ev = 1'b0;
    tmo_ev     = 1'b0;
    unique case (state)
      IDLE:
        if (start)
          state_d = (mode == 2'd1) ? RX_GO : TX_GO;
      TX_GO:
        state_d = TX_RUN;
      TX_RUN:
        if (tx_empty && !txd_busy && seen_busy) begin
          tx_done_ev = 1'b1;
          state_d    = (mode == 2'd2) ? RX_GO : IDLE;
        end
      RX_GO:
        state_d = RX_SEARCH;
      RX_SEARCH:
        if (rxd_aa_found)
          state_d = RX_RUN;
        else if (tmo != '0 && tmo_cnt <= TMO_W'(1)) begin
          tmo_ev  = 1'b1;
          state_d = IDLE;
        end
      RX_RUN:
        if (rxd_done)
          state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
    if (abort) begin
      state_d    = IDLE;
      tx_done_ev = 1'b0;
      tmo_ev     = 1'b0;
    end
  end

  // register read mux
  always_comb begin
    rd_d = 32'h0;
    unique case (1'b1)
      sel[0], sel[5]: rd_d = 32'h0;
      sel[1]:  rd_d = {30'h0, mode};
      sel[2]:  rd_d = aa;
      sel[3]:  rd_d = 32'(ch_idx);
      sel[4]:  rd_d = 32'(tmo);
      sel[6]:  rd_d = rx_empty ? 32'h0
                             : {24'h0, rxm[rx_rp]};
      sel[7]:  rd_d = {27'h0, crc_q, aa_hit,
                       rx_empty, tx_full, busy};
      sel[8]:  rd_d = 32'(tx_lvl);
      sel[9]:  rd_d = 32'(rx_lvl);
      sel[10]: rd_d = {27'h0, irq_en};
      sel[11]: rd_d = {27'h0, irq_stat};
      default: rd_d = 32'hFFFF_FFFF;
    endcase
  end

  // bus, config registers, sequencer state and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready     <= 1'b0;
      rdata     <= 32'h0;
      state     <= IDLE;
      tx_en     <= 1'b0;
      rx_en     <= 1'b0;
      mode      <= 2'd0;
      aa        <= AA_RST;
      ch_idx    <= CH_IDX_W'(5);
      tmo       <= '0;
      tmo_cnt   <= '0;
      irq_en    <= 5'h0;
      irq_stat  <= 5'h0;
      crc_q     <= 1'b0;
      aa_hit    <= 1'b0;
      seen_busy <= 1'b0;
    end else begin
      ready <= valid;
      if (acc)
        rdata <= rd_d;
      state <= state_d;
      tx_en <= state_d inside {TX_GO, TX_RUN};
      rx_en <= state_d inside {RX_GO, RX_SEARCH, RX_RUN};
      if (we && !busy) begin
        if (sel[1]) mode   <= wdata[1:0];
        if (sel[2]) aa     <= wdata;
        if (sel[3]) ch_idx <= wdata[CH_IDX_W-1:0];
        if (sel[4]) tmo    <= wdata[TMO_W-1:0];
      end
      if (we && sel[10])
        irq_en <= wdata[4:0];
      irq_stat <= (irq_stat & ~irq_clr) | irq_set;
      if (state == TX_GO)
        seen_busy <= 1'b0;
      else if (state == TX_RUN && txd_busy)
        seen_busy <= 1'b1;
      if (state == RX_GO)
        tmo_cnt <= tmo;
      else if (state == RX_SEARCH && tmo_cnt != '0)
        tmo_cnt <= tmo_cnt - TMO_W'(1);
      if (start)
        aa_hit <= 1'b0;
      else if (state == RX_SEARCH && rxd_aa_found)
        aa_hit <= 1'b1;
      if (rx_done_ev)
        crc_q <= rxd_crc_ok;
    end
  end

  // FIFO pointers and levels; abort flushes TX only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_lvl <= '0;
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_lvl <= '0;
    end else begin
      if (abort) begin
        tx_wp  <= '0;
        tx_rp  <= '0;
        tx_lvl <= '0;
      end else begin
        if (tx_push) tx_wp <= tx_wp + 1'b1;
        if (tx_pop)  tx_rp <= tx_rp + 1'b1;
        tx_lvl <= tx_lvl + (TXF_LOG2+1)'(tx_push)
                         - (TXF_LOG2+1)'(tx_pop);
      end
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      rx_lvl <= rx_lvl + (RXF_LOG2+1)'(rx_push)
                       - (RXF_LOG2+1)'(rx_pop);
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (tx_push) txm[tx_wp] <= wdata[7:0];
    if (rx_push) rxm[rx_wp] <= rxd_data;
  end

endmodule
